// File: rtl/sign_mag_sub_serial.sv
// Bit-serial sign-magnitude subtractor (diff = a - b), one magnitude bit per clock.
// Optional build macro SIGN_MAG_SUB_SAT_EN: saturate magnitude on effective-add overflow.
module sign_mag_sub_serial #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             overflow
);

  localparam int M  = WIDTH - 1;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST     = CW'(M);
  localparam logic [CW-1:0] CNT_FIX_LAST = CW'(M - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_r, state_next_s;
  logic [M-1:0]     a_mag_r, b_mag_r, res_r, res_shift_s;
  logic [CW-1:0]    cnt_r;
  logic             cy_r, cy_next_s, bit_s;
  logic             eff_add_r, sign_a_r, accept_s;
  logic [WIDTH-1:0] diff_r, diff_next_s;
  logic             ovf_r, ovf_next_s;
  logic             busy_r, done_r;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; CALC spends one extra cycle after the last bit to resolve the result
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          accept_s     = 1'b1;
          state_next_s = CALC;
        end else begin
          state_next_s = IDLE;
        end
      end
      CALC: begin
        if (cnt_r == CNT_LAST) begin
          if (!eff_add_r && cy_r) begin
            state_next_s = FIX;
          end else begin
            state_next_s = DONE;
          end
        end else begin
          state_next_s = CALC;
        end
      end
      FIX: begin
        if (cnt_r == CNT_FIX_LAST) begin
          state_next_s = DONE;
        end else begin
          state_next_s = FIX;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Serial bit cell: full add, full subtract, or negate (cy_r is the "first one seen" flag in FIX)
  always_comb begin
    bit_s     = 1'b0;
    cy_next_s = cy_r;
    if (state_r == FIX) begin
      bit_s     = res_r[0] ^ cy_r;
      cy_next_s = cy_r | res_r[0];
    end else if (eff_add_r) begin
      bit_s     = a_mag_r[0] ^ b_mag_r[0] ^ cy_r;
      cy_next_s = (a_mag_r[0] & b_mag_r[0]) | (cy_r & (a_mag_r[0] ^ b_mag_r[0]));
    end else begin
      bit_s     = a_mag_r[0] ^ b_mag_r[0] ^ cy_r;
      cy_next_s = (~a_mag_r[0] & b_mag_r[0]) | (~(a_mag_r[0] ^ b_mag_r[0]) & cy_r);
    end
    res_shift_s        = res_r >> 1;
    res_shift_s[M-1]   = bit_s;
  end

  // Result formation, consumed only on the edge entering DONE
  always_comb begin
    diff_next_s = diff_r;
    ovf_next_s  = ovf_r;
    if (state_r == CALC) begin
      if (eff_add_r) begin
`ifdef SIGN_MAG_SUB_SAT_EN
        if (cy_r) begin
          diff_next_s = {sign_a_r, {M{1'b1}}};
        end else begin
          diff_next_s = {sign_a_r, res_r};
        end
`else
        diff_next_s = {sign_a_r, res_r};
`endif
        ovf_next_s = cy_r;
      end else begin
        ovf_next_s = 1'b0;
        if (res_r == {M{1'b0}}) begin
          diff_next_s = {WIDTH{1'b0}};
        end else begin
          diff_next_s = {sign_a_r, res_r};
        end
      end
    end else if (state_r == FIX) begin
      diff_next_s = {~sign_a_r, res_shift_s};
      ovf_next_s  = 1'b0;
    end else begin
      diff_next_s = diff_r;
      ovf_next_s  = ovf_r;
    end
  end

  // Datapath registers and registered handshake outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_mag_r   <= {M{1'b0}};
      b_mag_r   <= {M{1'b0}};
      res_r     <= {M{1'b0}};
      cnt_r     <= {CW{1'b0}};
      cy_r      <= 1'b0;
      eff_add_r <= 1'b0;
      sign_a_r  <= 1'b0;
      diff_r    <= {WIDTH{1'b0}};
      ovf_r     <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      if (accept_s) begin
        a_mag_r   <= a[M-1:0];
        b_mag_r   <= b[M-1:0];
        eff_add_r <= a[M] ^ b[M];
        sign_a_r  <= a[M];
        res_r     <= {M{1'b0}};
        cy_r      <= 1'b0;
        cnt_r     <= {CW{1'b0}};
      end else if (state_r == CALC) begin
        if (cnt_r != CNT_LAST) begin
          a_mag_r <= a_mag_r >> 1;
          b_mag_r <= b_mag_r >> 1;
          res_r   <= res_shift_s;
          cy_r    <= cy_next_s;
          cnt_r   <= cnt_r + CW'(1);
        end else begin
          cy_r  <= 1'b0;
          cnt_r <= {CW{1'b0}};
        end
      end else if (state_r == FIX) begin
        res_r <= res_shift_s;
        cy_r  <= cy_next_s;
        cnt_r <= cnt_r + CW'(1);
      end
      if (state_next_s == DONE) begin
        diff_r <= diff_next_s;
        ovf_r  <= ovf_next_s;
      end
      done_r <= (state_next_s == DONE);
      busy_r <= (state_next_s == CALC) || (state_next_s == FIX);
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign diff     = diff_r;
  assign overflow = ovf_r;

endmodule

// File: tb/tb_sign_mag_sub_serial.sv
// Self-checking bench for sign_mag_sub_serial (WIDTH=4): directed plan cases plus random ops
// checked against an arithmetic reference model.
module tb_sign_mag_sub_serial;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [3:0] a, b, diff;
  logic       busy, done, overflow;
  int         compared = 0;
  int         mismatched = 0;
  logic [3:0] prev_d;
  bit         saw_done;

  sign_mag_sub_serial #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on sign and magnitude
  task automatic ref_model(input logic [3:0] x, input logic [3:0] y,
                           output logic [3:0] d, output logic o, output int lat);
    int ma, mb, m;
    logic [2:0] mm;
    logic s;
    ma = int'(x[2:0]);
    mb = int'(y[2:0]);
    if (x[3] != y[3]) begin
      m = ma + mb;
      o = (m > 7);
`ifdef SIGN_MAG_SUB_SAT_EN
      if (o) m = 7;
`endif
      m   = m % 8;
      s   = x[3];
      lat = 4;
    end else if (ma >= mb) begin
      m   = ma - mb;
      o   = 1'b0;
      s   = (m == 0) ? 1'b0 : x[3];
      lat = 4;
    end else begin
      m   = mb - ma;
      o   = 1'b0;
      s   = ~x[3];
      lat = 7;
    end
    mm = m[2:0];
    d  = {s, mm};
  endtask

  // Called at a negedge; returns at the negedge of the DONE cycle
  task automatic do_op(input logic [3:0] x, input logic [3:0] y, input bit hold, input bit chain);
    logic [3:0] ed;
    logic       eo;
    int         el, lat;
    bit         found;
    ref_model(x, y, ed, eo, el);
    a = x; b = y; start = 1'b1;
    @(posedge clk);
    lat = 0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        found = 1'b1;
        break;
      end
      if (lat == 0) begin
        chk("busy_after_accept", 32'(busy), 32'd1);
        chk("diff_held_during_op", 32'(diff), 32'(prev_d));
      end
      start = hold;
      a = 4'($urandom);
      b = 4'($urandom);
      @(posedge clk);
      lat++;
    end
    chk("done_seen", 32'(found), 32'd1);
    chk("latency", 32'(lat), 32'(el));
    chk("diff", 32'(diff), 32'(ed));
    chk("overflow", 32'(overflow), 32'(eo));
    chk("busy_in_done", 32'(busy), 32'd0);
    prev_d = ed;
    if (!chain) start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; a = 4'd0; b = 4'd0; prev_d = 4'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Plan cases, first one holding start high throughout
    do_op(4'b0011, 4'b0101, 1'b1, 1'b0);
    @(negedge clk); chk("done_pulse", 32'(done), 32'd0);
    do_op(4'b0110, 4'b1011, 1'b0, 1'b0);
    @(negedge clk);
    do_op(4'b1100, 4'b1100, 1'b0, 1'b0);
    @(negedge clk);
    do_op(4'b1000, 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    do_op(4'b1010, 4'b0010, 1'b0, 1'b0);
    @(negedge clk);

    // Back-to-back accepts in the DONE cycle
    do_op(4'b0011, 4'b0101, 1'b1, 1'b1);
    do_op(4'b0110, 4'b1011, 1'b0, 1'b1);
    do_op(4'b0001, 4'b0111, 1'b0, 1'b0);
    @(negedge clk); chk("done_pulse_b2b", 32'(done), 32'd0);

    // Abort two cycles into FIX
    a = 4'b0011; b = 4'b0101; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("busy_before_abort", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_diff", 32'(diff), 32'd0);
    chk("abort_ovf", 32'(overflow), 32'd0);
    prev_d = 4'd0;
    @(negedge clk); reset = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("no_done_after_abort", 32'(saw_done), 32'd0);
    do_op(4'b0101, 4'b0010, 1'b0, 1'b0);
    @(negedge clk);

    // Random operations, randomly chained and with start held
    for (int n = 0; n < 40; n++) begin
      logic ch;
      ch = 1'($urandom_range(0, 1));
      do_op(4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)), ch);
      if (!ch) begin
        @(negedge clk);
        chk("rand_done_pulse", 32'(done), 32'd0);
      end
    end
    start = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
